// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: handshake bundle between a producer/consumer pair and
// the sync_fifo_flex buffer.
//
// Parameters: WIDTH (data width), DEPTH (entries; sets the count width).
// Signals:
//   wr_en, data_in           write request and data (toward the FIFO)
//   rd_en                    read request / pop (toward the FIFO)
//   err_clr                  clears the sticky error flags (toward the FIFO)
//   data_out, valid          read data and its qualifier (from the FIFO)
//   full, empty              occupancy extremes (from the FIFO)
//   almost_full/empty        threshold flags (from the FIFO)
//   count                    occupancy 0..DEPTH (from the FIFO)
//   overflow, underflow      sticky error flags (from the FIFO)
//   parity_err               sticky parity error, present only when
//                            SYNC_FIFO_PARITY_EN is defined
// Modports: master = user side, slave = FIFO side.
interface sync_fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
`ifdef SYNC_FIFO_PARITY_EN
    logic             parity_err;

    modport master (
        output wr_en, data_in, rd_en, err_clr,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, parity_err
    );

    modport slave (
        input  wr_en, data_in, rd_en, err_clr,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, parity_err
    );
`else
    modport master (
        output wr_en, data_in, rd_en, err_clr,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, err_clr,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
`endif
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO of any depth (including non-power-of-two)
// with occupancy count, programmable almost-full/almost-empty flags, a
// selectable standard (1-cycle registered) or first-word-fall-through read
// path, and sticky overflow/underflow flags.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset (memory contents are kept)
//   bus   sync_fifo_flex_if.slave: wr_en/data_in/rd_en/err_clr in;
//         data_out/valid/full/empty/almost_full/almost_empty/count/
//         overflow/underflow out (plus parity_err, see below)
//
// Optional feature: define SYNC_FIFO_PARITY_EN to store an even-parity bit
// with every entry and raise the sticky bus.parity_err when a delivered
// word fails its parity check.
module sync_fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    sync_fifo_flex_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          full_w;
    logic          empty_w;
    logic          rd_acc;
    logic          wr_acc;
    logic [MW-1:0] head;
    logic [MW-1:0] wr_word;

    // Pointers wrap explicitly so any DEPTH works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A read while full frees a slot, so a same-cycle write is accepted.
    // An empty FIFO never bypasses a write to the read side.
    assign rd_acc = bus.rd_en && !empty_w;
    assign wr_acc = bus.wr_en && (!full_w || rd_acc);

    assign head = mem[rd_ptr];

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {^bus.data_in, bus.data_in};
`else
    assign wr_word = bus.data_in;
`endif

    // Storage is not reset. The only same-address read/write is full with
    // a simultaneous pop; head is read before this edge so it gets the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sticky errors: a new event in the same cycle as err_clr keeps the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    // Checked on every accepted pop: that is the word handed out, whether it
    // is registered (standard) or already on data_out (FWFT). A good entry
    // has even parity over {parity, data}.
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (rd_acc && (^head)) begin
            parity_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            parity_err_q <= 1'b0;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = head[WIDTH-1:0];
            assign bus.valid    = !empty_w;
        end else begin : g_std
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= head[WIDTH-1:0];
                    end
                end
            end

            assign bus.data_out = data_q;
            assign bus.valid    = valid_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
`timescale 1ns/1ps
module tb_sync_fifo_flex;
    localparam int N = 3;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_in;

    int n_vec = 0;
    int n_err = 0;

    // Per-instance configuration: 0 = 16 deep standard, 1 = 12 deep standard,
    // 2 = 5 deep FWFT.
    int dep_c [N];
    int af_c  [N];
    int ae_c  [N];
    int fw_c  [N];

    // Reference model: a queue per instance; bit 8 marks a corrupted entry.
    logic [8:0] mq [N][$];
    logic [7:0] m_dout  [N];
    logic       m_valid [N];
    logic       m_ovf   [N];
    logic       m_udf   [N];
    logic       m_perr  [N];
    int         rd_tot  [N];

    typedef struct packed {
        logic [31:0] cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        udf;
        logic        valid;
        logic        perr;
        logic [7:0]  dout;
    } obs_t;
    obs_t obs [N];
    logic perr_w [N];

    sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) if0 ();
    sync_fifo_flex_if #(.WIDTH(8), .DEPTH(12)) if1 ();
    sync_fifo_flex_if #(.WIDTH(8), .DEPTH(5))  if2 ();

    assign if0.wr_en = wr_en;  assign if0.data_in = data_in;
    assign if0.rd_en = rd_en;  assign if0.err_clr = err_clr;
    assign if1.wr_en = wr_en;  assign if1.data_in = data_in;
    assign if1.rd_en = rd_en;  assign if1.err_clr = err_clr;
    assign if2.wr_en = wr_en;  assign if2.data_in = data_in;
    assign if2.rd_en = rd_en;  assign if2.err_clr = err_clr;

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sync_fifo_flex #(.WIDTH(8), .DEPTH(12), .AF_THRESH(9), .AE_THRESH(3), .FWFT(0))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));

`ifdef SYNC_FIFO_PARITY_EN
    assign perr_w[0] = if0.parity_err;
    assign perr_w[1] = if1.parity_err;
    assign perr_w[2] = if2.parity_err;
`else
    assign perr_w[0] = 1'b0;
    assign perr_w[1] = 1'b0;
    assign perr_w[2] = 1'b0;
`endif

    assign obs[0] = {32'(if0.count), if0.full, if0.empty, if0.almost_full, if0.almost_empty,
                     if0.overflow, if0.underflow, if0.valid, perr_w[0], if0.data_out};
    assign obs[1] = {32'(if1.count), if1.full, if1.empty, if1.almost_full, if1.almost_empty,
                     if1.overflow, if1.underflow, if1.valid, perr_w[1], if1.data_out};
    assign obs[2] = {32'(if2.count), if2.full, if2.empty, if2.almost_full, if2.almost_empty,
                     if2.overflow, if2.underflow, if2.valid, perr_w[2], if2.data_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_tick();
        int n;
        logic ra, wa;
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mq[i].delete();
                m_dout[i]  = 8'h00;
                m_valid[i] = 1'b0;
                m_ovf[i]   = 1'b0;
                m_udf[i]   = 1'b0;
                m_perr[i]  = 1'b0;
                rd_tot[i]  = 0;
            end else begin
                n  = mq[i].size();
                ra = rd_en && (n != 0);
                wa = wr_en && ((n != dep_c[i]) || ra);
                m_ovf[i] = (wr_en && !wa) || (m_ovf[i] && !err_clr);
                m_udf[i] = (rd_en && (n == 0)) || (m_udf[i] && !err_clr);
                h = 9'h000;
                if (ra) h = mq[i].pop_front();
                m_perr[i]  = (ra && h[8]) || (m_perr[i] && !err_clr);
                m_valid[i] = ra;
                if (ra) begin
                    m_dout[i] = h[7:0];
                    rd_tot[i]++;
                end
                if (wa) mq[i].push_back({1'b0, data_in});
            end
        end
    endtask

    task automatic check_all();
        int n;
        for (int i = 0; i < N; i++) begin
            n = mq[i].size();
            chk($sformatf("d%0d.count", i), obs[i].cnt, 32'(n));
            chk($sformatf("d%0d.full", i), obs[i].full, n == dep_c[i]);
            chk($sformatf("d%0d.empty", i), obs[i].empty, n == 0);
            chk($sformatf("d%0d.almost_full", i), obs[i].af, n >= af_c[i]);
            chk($sformatf("d%0d.almost_empty", i), obs[i].ae, n <= ae_c[i]);
            chk($sformatf("d%0d.overflow", i), obs[i].ovf, m_ovf[i]);
            chk($sformatf("d%0d.underflow", i), obs[i].udf, m_udf[i]);
            if (fw_c[i] != 0) begin
                chk($sformatf("d%0d.valid", i), obs[i].valid, n != 0);
                if (n != 0) chk($sformatf("d%0d.data_out", i), obs[i].dout, mq[i][0][7:0]);
            end else begin
                chk($sformatf("d%0d.valid", i), obs[i].valid, m_valid[i]);
                chk($sformatf("d%0d.data_out", i), obs[i].dout, m_dout[i]);
            end
`ifdef SYNC_FIFO_PARITY_EN
            chk($sformatf("d%0d.parity_err", i), obs[i].perr, m_perr[i]);
`endif
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        err_clr = c;
        rst     = rs;
        @(posedge clk);
        model_tick();
        #1;
        check_all();
    endtask

    initial begin
        int idx;
        dep_c = '{16, 12, 5};
        af_c  = '{14, 9, 4};
        ae_c  = '{2, 3, 1};
        fw_c  = '{0, 0, 1};
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst.empty", obs[0].empty, 1'b1);
        chk("rst.almost_empty", obs[0].ae, 1'b1);
        chk("rst.data_out", obs[0].dout, 8'h00);

        // Fill 16-deep instance; almost_full follows the 14th write
        for (int k = 0; k < 16; k++) begin
            step(1, 8'(k), 0, 0, 0);
            if (k == 12) chk("t1.af_at13", obs[0].af, 1'b0);
            if (k == 13) chk("t1.af_at14", obs[0].af, 1'b1);
        end
        chk("t1.count16", obs[0].cnt, 32'd16);
        chk("t1.full", obs[0].full, 1'b1);
        step(1, 8'hAA, 0, 0, 0);
        chk("t1.overflow", obs[0].ovf, 1'b1);
        chk("t1.count_hold", obs[0].cnt, 32'd16);
        step(0, 8'h00, 0, 1, 0);
        chk("t1.ovf_clr", obs[0].ovf, 1'b0);

        // Full with simultaneous read and write
        step(1, 8'h55, 1, 0, 0);
        chk("t2.count", obs[0].cnt, 32'd16);
        chk("t2.ovf", obs[0].ovf, 1'b0);
        chk("t2.oldest", obs[0].dout, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            step(0, 8'h00, 1, 0, 0);
            chk("t1.rd_valid", obs[0].valid, 1'b1);
            chk("t1.rd_data", obs[0].dout, (k == 16) ? 8'h55 : 8'(k));
        end
        step(0, 8'h00, 0, 0, 0);
        chk("t1.valid_drop", obs[0].valid, 1'b0);
        chk("t1.dout_hold", obs[0].dout, 8'h55);

        // 12-deep instance: 30 write/read pairs wrap the pointers
        step(0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 30; k++) begin
            step(1, 8'(k), 0, 0, 0);
            chk("t3.count1", obs[1].cnt, 32'd1);
            step(0, 8'h00, 1, 0, 0);
            chk("t3.data", obs[1].dout, 8'(k));
            chk("t3.count0", obs[1].cnt, 32'd0);
        end

        // Read on empty with same-cycle write
        step(1, 8'h3C, 1, 0, 0);
        chk("t4.underflow", obs[0].udf, 1'b1);
        chk("t4.count", obs[0].cnt, 32'd1);
        chk("t4.no_read", obs[0].valid, 1'b0);
        step(0, 8'h00, 0, 1, 0);
        chk("t4.udf_clr", obs[0].udf, 1'b0);
        step(0, 8'h00, 1, 0, 0);
        chk("t4.data", obs[0].dout, 8'h3C);
        step(0, 8'h00, 1, 1, 0);
        chk("t4.clr_vs_event", obs[0].udf, 1'b1);
        step(0, 8'h00, 0, 1, 0);

        // FWFT instance
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hA1, 0, 0, 0);
        chk("t5.first", obs[2].dout, 8'hA1);
        chk("t5.valid", obs[2].valid, 1'b1);
        step(1, 8'hB2, 0, 0, 0);
        chk("t5.hold", obs[2].dout, 8'hA1);
        step(0, 8'h00, 1, 0, 0);
        chk("t5.second", obs[2].dout, 8'hB2);
        step(0, 8'h00, 1, 0, 0);
        chk("t5.empty", obs[2].empty, 1'b1);
        chk("t5.valid0", obs[2].valid, 1'b0);

`ifdef SYNC_FIFO_PARITY_EN
        // Corrupt a stored word and watch the parity flag
        step(0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 8'(8'h10 + k), 0, 0, 0);
        idx = (rd_tot[0] + 2) % dep_c[0];
        u0.mem[idx] <= u0.mem[idx] ^ 9'h001;
        mq[0][2] = mq[0][2] ^ 9'h101;
        #1;
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("t6.perr_clean", obs[0].perr, 1'b0);
        step(0, 8'h00, 1, 0, 0);
        chk("t6.perr_set", obs[0].perr, 1'b1);
        step(0, 8'h00, 0, 0, 0);
        chk("t6.perr_hold", obs[0].perr, 1'b1);
        step(0, 8'h00, 0, 1, 0);
        chk("t6.perr_clr", obs[0].perr, 1'b0);
        for (int k = 0; k < 3; k++) step(1, 8'(8'h20 + k), 0, 0, 0);
        idx = rd_tot[0] % dep_c[0];
        u0.mem[idx] <= u0.mem[idx] ^ 9'h100;
        mq[0][0] = mq[0][0] ^ 9'h100;
        #1;
        step(1, 8'h30, 1, 0, 0);
        chk("t6.perr_set2", obs[0].perr, 1'b1);
        step(0, 8'h00, 0, 0, 1);
        chk("t6.rst_count", obs[0].cnt, 32'd0);
        chk("t6.rst_perr", obs[0].perr, 1'b0);
`else
        idx = 0;
`endif

        // Randomized traffic: write-heavy then read-heavy
        step(0, 8'h00, 0, 0, 1);
        for (int k = 0; k < 1600; k++) begin
            if (k < 800)
                step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 5, $urandom_range(0, 299) == 0);
            else
                step($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 5, $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO. Successor to the basic synchronous FIFO.
- Supports arbitrary depth, including non-power-of-two.
- Keeps an occupancy count and reports programmable almost-full/almost-empty flags.
- Selectable standard or first-word-fall-through (FWFT) read mode; sticky overflow/underflow error flags.
- Sits between producer/consumer pipeline stages inside a single clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2, any integer).
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), count width (derived, not to be overridden).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request (pop)
- data_out  out  WIDTH  read data
- valid  out  1  data_out holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  CW  current occupancy 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers = 0, count = 0, data_out = 0, valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH >= 1).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words; it wins over every other input in the same cycle.
- Flags full, empty, almost_* are combinational decodes of the count register, so they update the cycle after the accepted transfer.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous read frees a slot and the write is accepted.
- Empty case: a read is rejected even if a write occurs the same cycle. No bypass.
- Simultaneous rd_acc and wr_acc leave count unchanged; both pointers advance.
- Pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly. Never rely on natural binary wrap.
- Count update: count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- overflow sets when wr_en && !wr_acc. underflow sets when rd_en && empty.
- Both error flags hold until err_clr or rst. If err_clr and a new error event occur in the same cycle, the flag stays set.
- Rejected operations change no other state.
- FWFT=0 (standard):
  - On rd_acc, data_out <= mem[rd_ptr] and valid <= 1 on the next edge (1-cycle read latency).
  - Without rd_acc, valid <= 0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acknowledges the presented word; the next word appears the cycle after.
  - First-write-to-valid latency is 1 cycle (count update).
- A write and a read to the same address in one cycle cannot occur except when full with a simultaneous read. In that case the read returns the old word.

Optional Feature:
SYNC_FIFO_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from data_in on write.
  - On a delivered read, parity is recomputed. The delivered read is the registered read for FWFT=0, or the head word when rd_acc for FWFT=1.
  - A mismatch asserts the extra output port parity_err (1 bit, sticky, cleared by err_clr/rst, reset 0).
- Undefined:
  - Port parity_err and the parity storage are absent.
  - Memory width is exactly WIDTH.

Test Plan:
1. Reset then 16 writes 0x00..0x0F (DEPTH=16, FWFT=0):
   - count reaches 16, full = 1.
   - almost_full asserts once count reaches 14 (visible the cycle after the 14th write).
   - 17th write 0xAA sets overflow and is not stored.
   - 16 reads return 0x00..0x0F in order, each valid 1 cycle after rd_en.
2. Full FIFO, rd_en=1 and wr_en=1 with data_in=0x55 for one cycle:
   - count stays 16, overflow stays 0, read returns oldest word.
   - 0x55 later emerges as the last word.
3. DEPTH=12: repeat 30 write/read pairs with data = index:
   - Pointers wrap at 11 -> 0.
   - Output sequence is 0..29 with no gaps or duplicates; count never exceeds 1.
4. Empty FIFO, rd_en=1 and wr_en=1 (0x3C) in the same cycle:
   - underflow sets, read rejected, count = 1 next cycle.
   - err_clr clears underflow.
5. FWFT=1: write 0xA1 then 0xB2:
   - data_out = 0xA1 and valid = 1 the cycle after the first write.
   - rd_en pops it; the next cycle data_out = 0xB2.
   - After a second pop, empty = 1 and valid = 0.
6. SYNC_FIFO_PARITY_EN: force a bit flip in a stored entry via hierarchical access:
   - The read of that entry sets parity_err.
   - parity_err holds until err_clr.
   - Mid-stream rst clears count, all flags and parity_err in the next cycle.
